// File: rtl/hex_frame_tx.sv
// ============================================================================
//  Module   : hex_frame_tx
//  Purpose  : Serialises NCH words of WIDTH bits into one ASCII hex text
//             frame (channel 0 first, MSB nibble first, SEP between channels,
//             CR and optional LF terminator) over a byte valid/ready link.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hex_frame_tx #(
  parameter int         WIDTH     = 32,
  parameter int         NCH       = 4,
  parameter logic [7:0] SEP       = 8'h2C,
  parameter int         ADD_LF    = 1,
  parameter int         UPPERCASE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NCH*WIDTH-1:0]   data,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             tx_byte,
  output logic                   tx_valid,
  input  logic                   tx_ready
);

  localparam int NDIG  = WIDTH / 4;
  localparam int NIB_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [NIB_W-1:0] c_NIB_TOP = NIB_W'(NDIG - 1);
  localparam logic [CH_W-1:0]  c_CH_LAST = CH_W'(NCH - 1);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_HEX  = 3'd1;
  localparam logic [2:0] c_SEP  = 3'd2;
  localparam logic [2:0] c_CR   = 3'd3;
  localparam logic [2:0] c_LF   = 3'd4;

  // Letter base offset: base + nibble lands on 'A'/'a' when nibble is 10.
  localparam logic [7:0] c_ALPHA_BASE = (UPPERCASE != 0) ? 8'h37 : 8'h57;

  logic [2:0]           r_state;
  logic [2:0]           w_next;
  logic [NIB_W-1:0]     r_nib;
  logic [CH_W-1:0]      r_ch;
  logic [NCH*WIDTH-1:0] r_data;
  logic                 r_done;
  logic [WIDTH-1:0]     w_word;
  logic [3:0]           w_nib;
  logic                 w_xfer;

  assign w_xfer = tx_valid && tx_ready;
  assign done   = r_done;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: advance only on an accepted byte, except IDLE which waits for start
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: if (start) w_next = c_HEX;
      c_HEX: begin
        if (w_xfer && (r_nib == '0)) begin
          w_next = (r_ch == c_CH_LAST) ? c_CR : c_SEP;
        end
      end
      c_SEP:  if (w_xfer) w_next = c_HEX;
      c_CR:   if (w_xfer) w_next = (ADD_LF != 0) ? c_LF : c_IDLE;
      c_LF:   if (w_xfer) w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  // Capture register, nibble/channel counters and the done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_nib  <= '0;
      r_ch   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_xfer && ((r_state == c_LF) || ((r_state == c_CR) && (ADD_LF == 0)));
      if ((r_state == c_IDLE) && start) begin
        r_data <= data;
        r_nib  <= c_NIB_TOP;
        r_ch   <= '0;
      end else if (w_xfer) begin
        if ((r_state == c_HEX) && (r_nib != '0)) begin
          r_nib <= r_nib - NIB_W'(1);
        end else if (r_state == c_SEP) begin
          r_ch  <= r_ch + CH_W'(1);
          r_nib <= c_NIB_TOP;
        end
      end
    end
  end

  // Select the current channel word and the nibble being sent
  always_comb begin
    w_word = '0;
    for (int k = 0; k < NCH; k++) begin
      if (r_ch == CH_W'(k)) w_word = r_data[k*WIDTH +: WIDTH];
    end
    w_nib = 4'h0;
    for (int n = 0; n < NDIG; n++) begin
      if (r_nib == NIB_W'(n)) w_nib = w_word[n*4 +: 4];
    end
  end

  // Output decode: the byte on the link is a pure function of state and counters
  always_comb begin
    tx_valid = (r_state != c_IDLE);
    busy     = (r_state != c_IDLE);
    tx_byte  = 8'h00;
    case (r_state)
      c_HEX: tx_byte = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib})
                                       : (c_ALPHA_BASE + {4'h0, w_nib});
      c_SEP: tx_byte = SEP;
      c_CR:  tx_byte = 8'h0D;
      c_LF:  tx_byte = 8'h0A;
      default: tx_byte = 8'h00;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_hex_frame_tx.sv
// ============================================================================
//  Module   : tb_hex_frame_tx
//  Purpose  : Directed + randomized bench for hex_frame_tx. Two instances:
//             u_a (NCH=1, CR+LF, uppercase) and u_b (NCH=2, CR only,
//             lowercase). Expected frames come from a text-level model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hex_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ready = 1'b0;
  logic [63:0] data = '0;
  bit          sel = 1'b0;

  logic       a_busy, a_done, a_valid;
  logic [7:0] a_byte;
  logic       b_busy, b_done, b_valid;
  logic [7:0] b_byte;
  logic       c_busy, c_done, c_valid;
  logic [7:0] c_byte;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  hex_frame_tx #(.WIDTH(32), .NCH(1), .SEP(8'h2C), .ADD_LF(1), .UPPERCASE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .data(data[31:0]),
    .busy(a_busy), .done(a_done), .tx_byte(a_byte), .tx_valid(a_valid), .tx_ready(ready)
  );

  hex_frame_tx #(.WIDTH(32), .NCH(2), .SEP(8'h2C), .ADD_LF(0), .UPPERCASE(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .data(data),
    .busy(b_busy), .done(b_done), .tx_byte(b_byte), .tx_valid(b_valid), .tx_ready(ready)
  );

  always_comb begin
    c_busy  = sel ? b_busy  : a_busy;
    c_done  = sel ? b_done  : a_done;
    c_valid = sel ? b_valid : a_valid;
    c_byte  = sel ? b_byte  : a_byte;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] hexc(input int v, input bit up);
    if (v < 10) return 8'(8'h30 + v);
    return 8'((up ? 8'h41 : 8'h61) + v - 10);
  endfunction

  // Reference text for the selected instance's frame
  task automatic build_exp(input logic [63:0] d);
    int nch;
    bit lf;
    bit up;
    nch = sel ? 2 : 1;
    lf  = !sel;
    up  = !sel;
    exp_q.delete();
    for (int c = 0; c < nch; c++) begin
      for (int n = 7; n >= 0; n--) exp_q.push_back(hexc(int'(d[c*32 + n*4 +: 4]), up));
      if (c < nch - 1) exp_q.push_back(8'h2C);
    end
    exp_q.push_back(8'h0D);
    if (lf) exp_q.push_back(8'h0A);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic next_ready(input int duty);
    if (duty >= 10) return 1'b1;
    return ($urandom_range(9, 0) < duty);
  endfunction

  task automatic launch(input logic [63:0] d, input int duty, input bit hold);
    tick();
    data  = d;
    start = 1'b1;
    build_exp(d);
    tick();
    if (!hold) start = 1'b0;
    ready = next_ready(duty);
  endtask

  // Consume one frame; checks bytes, hold-stability, and the done cycle.
  task automatic run_frame(input int duty, input int stop_after, input bit poke);
    int idx = 0;
    int cyc = 0;
    bit hold = 1'b0;
    bit poked = 1'b0;
    bit first = 1'b1;
    logic [7:0] hb = 8'h00;
    while (idx < exp_q.size() && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (first) begin
        check("first_valid", {7'h0, c_valid}, 8'h01);
        first = 1'b0;
      end
      if (hold) begin
        check("stall_valid", {7'h0, c_valid}, 8'h01);
        check("stall_byte", c_byte, hb);
      end
      if (c_valid && ready) begin
        check($sformatf("byte%0d", idx), c_byte, exp_q[idx]);
        idx++;
      end
      hold = c_valid && !ready;
      hb   = c_byte;
      if (stop_after > 0 && idx == stop_after) return;
      tick();
      ready = next_ready(duty);
      if (poke) begin
        if (idx == 3 && !poked) begin
          start = 1'b1;
          data  = ~data;
          poked = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
    end
    if (cyc >= 2000) check("frame_timeout", 8'h01, 8'h00);
    @(negedge clk);
    check("done_pulse", {7'h0, c_done}, 8'h01);
    check("done_busy", {7'h0, c_busy}, 8'h00);
    check("done_valid", {7'h0, c_valid}, 8'h00);
  endtask

  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_valid", {7'h0, c_valid}, 8'h00);
      check("idle_busy", {7'h0, c_busy}, 8'h00);
      check("idle_done", {7'h0, c_done}, 8'h00);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_a_byte", a_byte, 8'h00);
    check("rst_a_ctl", {5'h0, a_busy, a_done, a_valid}, 8'h00);
    check("rst_b_byte", b_byte, 8'h00);
    check("rst_b_ctl", {5'h0, b_busy, b_done, b_valid}, 8'h00);
  endtask

  initial begin
    // Reset values
    #2;
    check_reset_vals();
    tick();
    tick();
    rst_n = 1'b1;
    check_idle(2);

    // Fixed frame on the single-channel instance
    sel = 1'b0;
    launch(64'h0000_0000_1234_ABCD, 10, 1'b0);
    run_frame(10, 0, 1'b0);
    check_idle(2);

    // Fixed two-channel lowercase frame, CR only
    sel = 1'b1;
    launch({32'h0000_0009, 32'hDEAD_BEEF}, 10, 1'b0);
    run_frame(10, 0, 1'b0);
    check_idle(2);

    // Backpressure at ~30% ready duty
    sel = 1'b0;
    launch(64'h0000_0000_1234_ABCD, 3, 1'b0);
    run_frame(3, 0, 1'b0);
    check_idle(1);

    // Randomized frames on both instances, full and throttled rate
    for (int i = 0; i < 6; i++) begin
      sel = i[0];
      launch({$urandom(), $urandom()}, (i < 3) ? 10 : 3, 1'b0);
      run_frame((i < 3) ? 10 : 3, 0, 1'b0);
    end

    // start pulsed mid-frame with new data: ignored, no second frame
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      launch({$urandom(), $urandom()}, 10, 1'b0);
      run_frame(10, 0, 1'b1);
      check_idle(4);
    end

    // Async reset after the 4th byte, then a fresh frame
    sel = 1'b0;
    launch({$urandom(), $urandom()}, 10, 1'b0);
    run_frame(10, 4, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    tick();
    rst_n = 1'b1;
    ready = 1'b0;
    check_idle(2);
    launch(64'h0000_0000_0000_000F, 10, 1'b0);
    run_frame(10, 0, 1'b0);
    check_idle(1);

    // start held high: back-to-back frames with only the done cycle between
    sel = 1'b0;
    launch({$urandom(), $urandom()}, 10, 1'b1);
    run_frame(10, 0, 1'b0);
    run_frame(10, 0, 1'b0);
    tick();
    start = 1'b0;
    run_frame(10, 0, 1'b0);
    check_idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
